// File: rtl/neuron_pkg.sv
// Shared definitions for the CORDIC neuron sequencer: data width, Q-format, FSM states, saturation limits.
package neuron_pkg;

    // MSB index of a data word (words are NRN_WIDTH+1 bits, Q2.13)
    localparam int unsigned NRN_WIDTH = 15;
    localparam int unsigned FRAC_BITS = 13;

    localparam logic [NRN_WIDTH:0] SAT_MAX = {1'b0, {NRN_WIDTH{1'b1}}};
    localparam logic [NRN_WIDTH:0] SAT_MIN = {1'b1, {NRN_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/neuron_sequencer_sat_add.sv
// sat_add: combinational signed saturating adder of two WIDTH+1 bit words.
module sat_add #(
    parameter int unsigned WIDTH = 15
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_b,
    output logic [WIDTH:0] o_sum_c
);

    logic [WIDTH+1:0] w_sum;

    // Add one guard bit, clamp when the guard and sign bits disagree
    always_comb begin
        w_sum   = {i_a[WIDTH], i_a} + {i_b[WIDTH], i_b};
        o_sum_c = w_sum[WIDTH:0];
        if (w_sum[WIDTH+1] != w_sum[WIDTH]) begin
            o_sum_c = w_sum[WIDTH+1] ? {1'b1, {WIDTH{1'b0}}} : {1'b0, {WIDTH{1'b1}}};
        end
    end

endmodule

// File: rtl/neuron_sequencer.sv
// neuron_sequencer: feeds operand triples into the CORDIC neuron core, sequences its
// restart, captures sinh/cosh/z and presents them with exp = sat(cosh + sinh).
// Optional RUN watchdog enabled by defining NEURON_SEQ_TIMEOUT_EN.
module neuron_sequencer
    import neuron_pkg::*;
#(
    parameter int unsigned WIDTH       = NRN_WIDTH,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_x,
    input  logic [WIDTH:0]   in_y,
    input  logic [WIDTH:0]   in_z,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH:0]   nrn_x,
    output logic [WIDTH:0]   nrn_y,
    output logic [WIDTH:0]   nrn_z,
    output logic             nrn_reset,
    input  logic [WIDTH:0]   nrn_sinh,
    input  logic [WIDTH:0]   nrn_cosh,
    input  logic [WIDTH:0]   nrn_z_res,
    input  logic             nrn_complete,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sinh,
    output logic [WIDTH:0]   out_cosh,
    output logic [WIDTH:0]   out_z,
    output logic [WIDTH:0]   out_exp,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    localparam int unsigned LCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LCNT_W-1:0]  r_lcnt;
    logic               r_nrn_reset;
    logic               r_busy;
    logic [WIDTH:0]     r_nrn_x, r_nrn_y, r_nrn_z;
    logic [TAG_W-1:0]   r_job_tag;
    logic               r_out_valid;
    logic [WIDTH:0]     r_out_sinh, r_out_cosh, r_out_z, r_out_exp;
    logic [TAG_W-1:0]   r_out_tag;
    logic [WIDTH:0]     w_exp_c;
    logic               w_accept;
    logic               w_capture;
    logic               w_release;
    logic               w_timeout;

    assign in_ready  = (r_state == IDLE);
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_capture = (r_state == RUN) && (nrn_complete || w_timeout);
    assign w_release = (r_state == HOLD) && out_ready;

    sat_add #(.WIDTH(WIDTH)) u_sat_add (
        .i_a     (nrn_cosh),
        .i_b     (nrn_sinh),
        .o_sum_c (w_exp_c)
    );

    // Next-state logic; complete is only looked at in RUN so a stale flag is masked in LAUNCH
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)       w_state_nxt = LAUNCH;
            LAUNCH:  if (r_lcnt == '0)   w_state_nxt = RUN;
            RUN:     if (nrn_complete || w_timeout) w_state_nxt = HOLD;
            HOLD:    if (out_ready)      w_state_nxt = IDLE;
            default:                     w_state_nxt = IDLE;
        endcase
    end

    // State register; core restart is released only while running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_nrn_reset <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_nrn_reset <= (w_state_nxt != RUN);
            r_busy      <= (w_state_nxt == LAUNCH) || (w_state_nxt == RUN);
        end
    end

    // Operand launch, restart down-counter and result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lcnt      <= '0;
            r_nrn_x     <= '0;
            r_nrn_y     <= '0;
            r_nrn_z     <= '0;
            r_job_tag   <= '0;
            r_out_valid <= 1'b0;
            r_out_sinh  <= '0;
            r_out_cosh  <= '0;
            r_out_z     <= '0;
            r_out_exp   <= '0;
            r_out_tag   <= '0;
        end else begin
            if (w_accept) begin
                r_nrn_x   <= in_x;
                r_nrn_y   <= in_y;
                r_nrn_z   <= in_z;
                r_job_tag <= in_tag;
                r_lcnt    <= LCNT_W'(RST_CYCLES - 1);
            end else if ((r_state == LAUNCH) && (r_lcnt != '0)) begin
                r_lcnt <= r_lcnt - LCNT_W'(1);
            end

            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_tag   <= r_job_tag;
                if (nrn_complete) begin
                    r_out_sinh <= nrn_sinh;
                    r_out_cosh <= nrn_cosh;
                    r_out_z    <= nrn_z_res;
                    r_out_exp  <= w_exp_c;
                end else begin
                    r_out_sinh <= '0;
                    r_out_cosh <= '0;
                    r_out_z    <= '0;
                    r_out_exp  <= '0;
                end
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef NEURON_SEQ_TIMEOUT_EN
    localparam int unsigned RUN_CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [RUN_CNT_W-1:0] r_run_cnt;
    logic                 r_out_err;

    assign w_timeout = (r_state == RUN) && !nrn_complete &&
                       (r_run_cnt == RUN_CNT_W'(TIMEOUT_CYC - 1));
    assign out_err   = r_out_err;

    // Watchdog: counts RUN cycles, flags the result when the core never completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run_cnt <= '0;
            r_out_err <= 1'b0;
        end else begin
            if (r_state != RUN) r_run_cnt <= '0;
            else                r_run_cnt <= r_run_cnt + RUN_CNT_W'(1);

            if (w_capture)      r_out_err <= w_timeout;
            else if (w_release) r_out_err <= 1'b0;
        end
    end
`else
    // Watchdog compiled out: RUN waits for the core indefinitely
    assign w_timeout = 1'b0 & (TIMEOUT_CYC == 0);
    assign out_err   = 1'b0;
`endif

    assign nrn_x     = r_nrn_x;
    assign nrn_y     = r_nrn_y;
    assign nrn_z     = r_nrn_z;
    assign nrn_reset = r_nrn_reset;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_sinh  = r_out_sinh;
    assign out_cosh  = r_out_cosh;
    assign out_z     = r_out_z;
    assign out_exp   = r_out_exp;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed scoreboard bench for neuron_sequencer with a behavioural core model.
module tb_neuron_sequencer;
    import neuron_pkg::*;

    localparam int unsigned TB_TIMEOUT = 8;

    typedef struct packed {
        logic [15:0] sinh;
        logic [15:0] cosh;
        logic [15:0] z;
        logic [15:0] ex;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [15:0] in_x, in_y, in_z;
    logic [3:0]  in_tag;
    logic [15:0] nrn_x, nrn_y, nrn_z;
    logic        nrn_reset;
    logic [15:0] nrn_sinh, nrn_cosh, nrn_z_res;
    logic        nrn_complete;
    logic        out_valid, out_ready;
    logic [15:0] out_sinh, out_cosh, out_z, out_exp;
    logic [3:0]  out_tag;
    logic        out_err, busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    // Core model: counts cycles with restart low, raises complete after m_lat of them
    int   m_lat   = 0;
    bit   m_stale = 1'b0;
    int   m_cnt;

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset)         m_cnt <= 0;
        else if (nrn_reset) m_cnt <= 0;
        else if (m_cnt < 1000) m_cnt <= m_cnt + 1;
    end

    assign nrn_complete = m_stale || ((m_lat != 0) && (m_cnt >= m_lat));

    neuron_sequencer #(
        .WIDTH(15), .TAG_W(4), .RST_CYCLES(2), .TIMEOUT_CYC(TB_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag),
        .nrn_x(nrn_x), .nrn_y(nrn_y), .nrn_z(nrn_z), .nrn_reset(nrn_reset),
        .nrn_sinh(nrn_sinh), .nrn_cosh(nrn_cosh), .nrn_z_res(nrn_z_res),
        .nrn_complete(nrn_complete),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sinh(out_sinh), .out_cosh(out_cosh), .out_z(out_z), .out_exp(out_exp),
        .out_tag(out_tag), .out_err(out_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // One job: accept, wait for result, compare against scoreboard, backpressure, release
    task automatic run_job(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                           input logic [3:0] tag, input logic [15:0] sh, input logic [15:0] ch,
                           input logic [15:0] zr, input logic [15:0] ex, input int lat,
                           input int exp_lat_in, input int hold);
        exp_t e;
        exp_t got;
        int   exp_lat;
        int   n;
        exp_lat = exp_lat_in;
        e = '{sinh: sh, cosh: ch, z: zr, ex: ex, tag: tag, err: 1'b0};
`ifdef NEURON_SEQ_TIMEOUT_EN
        if ((lat == 0) || (lat + 1 > int'(TB_TIMEOUT))) begin
            exp_lat = 2 + int'(TB_TIMEOUT);
            e = '{sinh: 16'h0, cosh: 16'h0, z: 16'h0, ex: 16'h0, tag: tag, err: 1'b1};
        end
`endif
        nrn_sinh  = sh;
        nrn_cosh  = ch;
        nrn_z_res = zr;
        m_lat     = lat;
        check("in_ready_idle", in_ready, 1);
        in_x = x; in_y = y; in_z = z; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(e);
        check("nrn_x", nrn_x, x);
        check("nrn_y", nrn_y, y);
        check("nrn_z", nrn_z, z);
        check("launch_busy", busy, 1);
        check("launch_in_ready", in_ready, 0);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check("nrn_reset_launch", nrn_reset, 1);
            if (n == 2) check("nrn_reset_run", nrn_reset, 0);
        end
        check("latency", n, exp_lat);
        got = sb.pop_front();
        check("out_sinh", out_sinh, got.sinh);
        check("out_cosh", out_cosh, got.cosh);
        check("out_z", out_z, got.z);
        check("out_exp", out_exp, got.ex);
        check("out_tag", out_tag, got.tag);
        check("out_err", out_err, got.err);
        check("hold_nrn_reset", nrn_reset, 1);
        repeat (hold) begin
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_exp", out_exp, got.ex);
            check("bp_tag", out_tag, got.tag);
            check("bp_in_ready", in_ready, 0);
            check("bp_nrn_reset", nrn_reset, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("rel_valid", out_valid, 0);
        check("rel_in_ready", in_ready, 1);
        check("rel_err", out_err, 0);
        check("rel_nrn_x_hold", nrn_x, x);
    endtask

    initial begin
        int seen;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_x = '0; in_y = '0; in_z = '0; in_tag = '0;
        nrn_sinh = '0; nrn_cosh = '0; nrn_z_res = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_nrn_reset", nrn_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_exp", out_exp, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_err", out_err, 0);
        check("rst_nrn_x", nrn_x, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Nominal z = 0.5 job with 10 cycles of backpressure
        run_job(16'h2000, 16'h0000, 16'h0001 << (FRAC_BITS - 1), 4'd3,
                16'h10AD, 16'h2415, 16'h0002, 16'h34C2, 20, 23, 10);
        // Positive and negative saturation
        run_job(16'h1111, 16'h2222, 16'h0333, 4'd5,
                16'h6000, 16'h7000, 16'h0004, SAT_MAX, 5, 8, 0);
        run_job(16'hA5A5, 16'h5A5A, 16'hF000, 4'hA,
                16'hF000, 16'h8000, 16'hFFFF, SAT_MIN, 1, 4, 2);
        // Complete already high through LAUNCH: captured on first RUN cycle
        m_stale = 1'b1;
        run_job(16'h0F0F, 16'h00FF, 16'h0123, 4'd7,
                16'h0100, 16'h2000, 16'h0005, 16'h2100, 1, 3, 0);
        m_stale = 1'b0;
`ifdef NEURON_SEQ_TIMEOUT_EN
        // Core never completes: watchdog result, then a normal job clears out_err
        run_job(16'h4444, 16'h5555, 16'h0666, 4'd9,
                16'h1234, 16'h2345, 16'h0777, 16'h0000, 0, 0, 1);
`endif
        run_job(16'h0001, 16'h0002, 16'h0003, 4'hC,
                16'h0010, 16'h1000, 16'h0020, 16'h1010, 3, 6, 0);

        // Asynchronous reset in RUN drops the job
        nrn_sinh = 16'h1111; nrn_cosh = 16'h2222; m_lat = 20;
        in_x = 16'h7777; in_tag = 4'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrun_nrn_reset", nrn_reset, 0);
        reset = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_nrn_reset", nrn_reset, 1);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("arst_no_output", seen, 0);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
